// File: rtl/comp_serial_n_bit_if.sv
// Request/result bundle for the serial N-bit comparator.
// The master drives start and the operands. The slave returns status and results.
interface comp_serial_n_bit_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned IDXW  = $clog2(WIDTH)
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             eq;
    logic             gt;
    logic             lt;
    logic [IDXW-1:0]  diff_idx;

    modport master (
        output start, a, b,
        input  busy, done, eq, gt, lt, diff_idx
    );

    modport slave (
        input  start, a, b,
        output busy, done, eq, gt, lt, diff_idx
    );
endinterface

// File: rtl/comp_serial_n_bit.sv
// Sequential N-bit comparator. It captures both operands on start and walks them MSB-first,
// one bit per clock, stopping at the first mismatching bit.
module comp_serial_n_bit #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    comp_serial_n_bit_if.slave    bus
);
    localparam int unsigned IDXW = $clog2(WIDTH);

    typedef enum logic {IDLE, CMP} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [IDXW-1:0]  cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             eq_q, eq_d;
    logic             gt_q, gt_d;
    logic             lt_q, lt_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic             bit_eq;

    // 1-bit equality cell applied to the current MSB tap.
    assign bit_eq = ~(sa_q[WIDTH-1] ^ sb_q[WIDTH-1]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            eq_q    <= 1'b0;
            gt_q    <= 1'b0;
            lt_q    <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            eq_q    <= eq_d;
            gt_q    <= gt_d;
            lt_q    <= lt_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        eq_d    = eq_q;
        gt_d    = gt_q;
        lt_d    = lt_q;
        idx_d   = idx_q;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    sa_d    = bus.a;
                    sb_d    = bus.b;
                    cnt_d   = IDXW'(WIDTH - 1);
                    eq_d    = 1'b0;
                    gt_d    = 1'b0;
                    lt_d    = 1'b0;
                    idx_d   = '0;
                    busy_d  = 1'b1;
                    state_d = CMP;
                end
            end
            CMP: begin
                if (!bit_eq) begin
                    gt_d    = sa_q[WIDTH-1];
                    lt_d    = ~sa_q[WIDTH-1];
                    idx_d   = cnt_q;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else if (cnt_q == '0) begin
                    eq_d    = 1'b1;
                    idx_d   = '0;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    sa_d    = {sa_q[WIDTH-2:0], 1'b0};
                    sb_d    = {sb_q[WIDTH-2:0], 1'b0};
                    cnt_d   = cnt_q - IDXW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.eq       = eq_q;
    assign bus.gt       = gt_q;
    assign bus.lt       = lt_q;
    assign bus.diff_idx = idx_q;
endmodule

// File: tb/tb_comp_serial_n_bit.sv
// Directed bench for comp_serial_n_bit at WIDTH=8. Expected values are hand-derived from operand bit patterns.
module tb_comp_serial_n_bit;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    comp_serial_n_bit_if #(.WIDTH(8)) bus ();

    comp_serial_n_bit #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts edges after the accepting edge until done is seen (bounded).
    task automatic wait_done(input int limit, output int edges);
        edges = 0;
        while (edges < limit) begin
            tick();
            edges++;
            if (bus.done) break;
        end
    endtask

    task automatic start_cmp(input logic [7:0] av, input logic [7:0] bv);
        bus.a     = av;
        bus.b     = bv;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic test_reset();
        logic [8:0] st;
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.a = '0;
        bus.b = '0;
        repeat (3) tick();
        st = {bus.busy, bus.done, bus.eq, bus.gt, bus.lt, bus.diff_idx};
        checks++;
        if (st !== 9'h000) begin
            errors++;
            $display("FAIL reset_state got %b exp %b", st, 9'h000);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_equal();
        int edges;
        start_cmp(8'hA5, 8'hA5);
        checks++;
        if ({bus.busy, bus.done, bus.eq, bus.gt, bus.lt} !== 5'b10000) begin
            errors++;
            $display("FAIL equal_busy got %b exp %b", {bus.busy, bus.done, bus.eq, bus.gt, bus.lt}, 5'b10000);
        end
        wait_done(20, edges);
        checks++;
        if (edges !== 8 || bus.done !== 1'b1) begin
            errors++;
            $display("FAIL equal_latency got %0d done %b exp 8", edges, bus.done);
        end
        checks++;
        if ({bus.busy, bus.eq, bus.gt, bus.lt, bus.diff_idx} !== 7'b0100000) begin
            errors++;
            $display("FAIL equal_result got %b exp %b", {bus.busy, bus.eq, bus.gt, bus.lt, bus.diff_idx}, 7'b0100000);
        end
        tick();
        checks++;
        if ({bus.done, bus.eq, bus.gt, bus.lt} !== 4'b0100) begin
            errors++;
            $display("FAIL equal_hold got %b exp %b", {bus.done, bus.eq, bus.gt, bus.lt}, 4'b0100);
        end
    endtask

    task automatic test_msb_exit();
        int edges;
        start_cmp(8'h80, 8'h00);
        wait_done(20, edges);
        checks++;
        if (edges !== 1) begin
            errors++;
            $display("FAIL msb_latency got %0d exp 1", edges);
        end
        checks++;
        if ({bus.busy, bus.eq, bus.gt, bus.lt, bus.diff_idx} !== 7'b0010111) begin
            errors++;
            $display("FAIL msb_result got %b exp %b", {bus.busy, bus.eq, bus.gt, bus.lt, bus.diff_idx}, 7'b0010111);
        end
        tick();
        checks++;
        if (bus.done !== 1'b0) begin
            errors++;
            $display("FAIL msb_done_pulse got %b exp 0", bus.done);
        end
    endtask

    task automatic test_lsb_mismatch();
        int edges;
        start_cmp(8'h12, 8'h13);
        wait_done(20, edges);
        checks++;
        if (edges !== 8) begin
            errors++;
            $display("FAIL lsb_latency got %0d exp 8", edges);
        end
        checks++;
        if ({bus.eq, bus.gt, bus.lt, bus.diff_idx} !== 6'b001000) begin
            errors++;
            $display("FAIL lsb_result got %b exp %b", {bus.eq, bus.gt, bus.lt, bus.diff_idx}, 6'b001000);
        end
        tick();
    endtask

    task automatic test_start_while_busy();
        int edges;
        start_cmp(8'h0F, 8'h0E);
        tick();
        bus.a     = 8'hFF;
        bus.b     = 8'h00;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        wait_done(20, edges);
        checks++;
        if (edges + 2 !== 8) begin
            errors++;
            $display("FAIL busy_start_latency got %0d exp 8", edges + 2);
        end
        checks++;
        if ({bus.eq, bus.gt, bus.lt, bus.diff_idx} !== 6'b010000) begin
            errors++;
            $display("FAIL busy_start_result got %b exp %b", {bus.eq, bus.gt, bus.lt, bus.diff_idx}, 6'b010000);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int edges;
        bus.a     = 8'h40;
        bus.b     = 8'h60;
        bus.start = 1'b1;
        tick();
        bus.a = 8'h33;
        bus.b = 8'h33;
        wait_done(20, edges);
        checks++;
        if (edges !== 3) begin
            errors++;
            $display("FAIL b2b_first_latency got %0d exp 3", edges);
        end
        checks++;
        if ({bus.eq, bus.gt, bus.lt, bus.diff_idx} !== 6'b001101) begin
            errors++;
            $display("FAIL b2b_first_result got %b exp %b", {bus.eq, bus.gt, bus.lt, bus.diff_idx}, 6'b001101);
        end
        tick();
        bus.start = 1'b0;
        checks++;
        if ({bus.busy, bus.done, bus.eq, bus.gt, bus.lt, bus.diff_idx} !== 8'b10000000) begin
            errors++;
            $display("FAIL b2b_accept got %b exp %b", {bus.busy, bus.done, bus.eq, bus.gt, bus.lt, bus.diff_idx}, 8'b10000000);
        end
        wait_done(20, edges);
        checks++;
        if (edges !== 8) begin
            errors++;
            $display("FAIL b2b_second_latency got %0d exp 8", edges);
        end
        checks++;
        if ({bus.eq, bus.gt, bus.lt, bus.diff_idx} !== 6'b100000) begin
            errors++;
            $display("FAIL b2b_second_result got %b exp %b", {bus.eq, bus.gt, bus.lt, bus.diff_idx}, 6'b100000);
        end
        tick();
    endtask

    task automatic test_reset_mid_op();
        int edges;
        int pulses;
        start_cmp(8'h01, 8'h02);
        tick();
        @(posedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.busy, bus.done, bus.eq, bus.gt, bus.lt} !== 5'b00000) begin
            errors++;
            $display("FAIL reset_mid_outputs got %b exp %b", {bus.busy, bus.done, bus.eq, bus.gt, bus.lt}, 5'b00000);
        end
        pulses = 0;
        repeat (4) begin
            tick();
            if (bus.done) pulses++;
        end
        rst_n = 1'b1;
        repeat (8) begin
            tick();
            if (bus.done) pulses++;
        end
        checks++;
        if (pulses !== 0) begin
            errors++;
            $display("FAIL reset_mid_no_done got %0d exp 0", pulses);
        end
        start_cmp(8'h01, 8'h02);
        wait_done(20, edges);
        checks++;
        if (edges !== 7) begin
            errors++;
            $display("FAIL reset_fresh_latency got %0d exp 7", edges);
        end
        checks++;
        if ({bus.eq, bus.gt, bus.lt, bus.diff_idx} !== 6'b001001) begin
            errors++;
            $display("FAIL reset_fresh_result got %b exp %b", {bus.eq, bus.gt, bus.lt, bus.diff_idx}, 6'b001001);
        end
        tick();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_equal();
        test_msb_exit();
        test_lsb_mismatch();
        test_start_while_busy();
        test_back_to_back();
        test_reset_mid_op();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
